piradip_shift_arbiter: RTL and testbench

- Shares one AXI-stream barrel shifter among NUM_REQ requester streams, with packet-level round-robin arbitration.
- Each input beat carries {shift, data}. The arbiter forwards granted beats to the shifter's input port.
- It records the requester index of every beat in a tag FIFO and uses it to route each shifter result back to the correct requester.
- Sits between requester datapaths and a single left-shifter instance (pipelined or combinational, any latency, order-preserving).

---
 rtl/piradip_shift_arb_pkg.sv | 31 +++
 rtl/piradip_shift_arbiter_tag.sv | 54 +++++
 rtl/piradip_shift_arbiter.sv | 133 +++++++++++++
 tb/tb_piradip_shift_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piradip_shift_arb_pkg.sv
// piradip_shift_arb_pkg: shared FSM state type and round-robin helper
// for the shared barrel-shifter arbiter.
package piradip_shift_arb_pkg;

  localparam int MAX_REQ = 32;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

  // Scans ptr, ptr+1, ... (mod n) and returns the first set bit.
  // The scan runs backwards so the earliest hit in scan order wins.
  function automatic int rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input int                 ptr,
    input int                 n
  );
    int pick;
    int idx;
    pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (valid[idx[4:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/piradip_shift_arbiter_tag.sv
// piradip_tag_fifo: requester-tag FIFO, push/pop with sync reset.
// Ports: push_i/pop_i/din_i in; dout_o (head), full_o, empty_o, count_o out.
module piradip_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/piradip_shift_arbiter.sv
// piradip_shift_arbiter: packet round-robin front end for one shared shifter.
// Ports: req_* per-requester in, sh_in_*/sh_out_* shifter side, rsp_* results,
// inflight tag count, err_orphan sticky untagged-result flag.
module piradip_shift_arbiter
  import piradip_shift_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int SHIFT_WIDTH  = 6,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_REQ-1:0]                           req_tvalid,
  output logic [NUM_REQ-1:0]                           req_tready,
  input  logic [NUM_REQ*(SHIFT_WIDTH+DATA_WIDTH)-1:0]  req_tdata,
  input  logic [NUM_REQ-1:0]                           req_tlast,
  output logic [NUM_REQ-1:0]                           rsp_tvalid,
  input  logic [NUM_REQ-1:0]                           rsp_tready,
  output logic [DATA_WIDTH-1:0]                        rsp_tdata,
  output logic                                         rsp_tlast,
  output logic                                         sh_in_tvalid,
  input  logic                                         sh_in_tready,
  output logic                                         sh_in_tlast,
  output logic [SHIFT_WIDTH+DATA_WIDTH-1:0]            sh_in_tdata,
  input  logic                                         sh_out_tvalid,
  output logic                                         sh_out_tready,
  input  logic                                         sh_out_tlast,
  input  logic [DATA_WIDTH-1:0]                        sh_out_tdata,
  output logic [$clog2(MAX_INFLIGHT):0]                inflight,
  output logic                                         err_orphan
);

  localparam int W  = SHIFT_WIDTH + DATA_WIDTH;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;

  typedef logic [IW-1:0] req_idx_t;

  arb_state_t         state_q;
  req_idx_t           grant_q;
  req_idx_t           rr_ptr_q;
  req_idx_t           pick_d;
  req_idx_t           rr_next_d;
  req_idx_t           head;
  logic               err_q;
  logic               full;
  logic               empty;
  logic               burst;
  logic               in_hs;
  logic               out_hs;
  logic [MAX_REQ-1:0] valid_ext;
  logic [CW-1:0]      count;

  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_REQ-1:0] = req_tvalid;
    pick_d = req_idx_t'(rr_pick(valid_ext, int'(rr_ptr_q), NUM_REQ));
  end

  assign rr_next_d = (grant_q == req_idx_t'(NUM_REQ - 1)) ?
                     '0 : grant_q + req_idx_t'(1);

  // Reset gates every handshake so nothing moves while it is held.
  assign burst = (state_q == BURST) & ~reset;

  always_comb begin
    req_tready   = '0;
    sh_in_tvalid = burst & req_tvalid[grant_q] & ~full;
    if (burst) req_tready[grant_q] = sh_in_tready & ~full;
  end

  assign sh_in_tdata = req_tdata[int'(grant_q)*W +: W];
  assign sh_in_tlast = req_tlast[grant_q];
  assign in_hs       = sh_in_tvalid & sh_in_tready;

  always_comb begin
    rsp_tvalid    = '0;
    sh_out_tready = 1'b0;
    if (!reset && !empty) begin
      rsp_tvalid[head] = sh_out_tvalid;
      sh_out_tready    = rsp_tready[head];
    end
  end

  assign rsp_tdata  = sh_out_tdata;
  assign rsp_tlast  = sh_out_tlast;
  assign out_hs     = sh_out_tvalid & sh_out_tready;
  assign inflight   = count;
  assign err_orphan = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (sh_out_tvalid && empty) err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (|req_tvalid && !full) begin
            grant_q <= pick_d;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (in_hs && sh_in_tlast) begin
            rr_ptr_q <= rr_next_d;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  piradip_tag_fifo #(
    .WIDTH (IW),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (in_hs),
    .pop_i   (out_hs),
    .din_i   (grant_q),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

endmodule

// File: tb/tb_piradip_shift_arbiter.sv
// tb_piradip_shift_arbiter: directed scoreboard bench for the arbiter
// with a 3-cycle order-preserving shifter model on the shifter ports.
`timescale 1ns/1ps
module tb_piradip_shift_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int SW  = 6;
  localparam int W   = SW + DW;
  localparam int MI  = 8;
  localparam int CW  = 4;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_tvalid = '0;
  logic [N-1:0]    req_tready;
  logic [N*W-1:0]  req_tdata = '0;
  logic [N-1:0]    req_tlast = '0;
  logic [N-1:0]    rsp_tvalid;
  logic [N-1:0]    rsp_tready = '1;
  logic [DW-1:0]   rsp_tdata;
  logic            rsp_tlast;
  logic            sh_in_tvalid;
  logic            sh_in_tready = 1'b1;
  logic            sh_in_tlast;
  logic [W-1:0]    sh_in_tdata;
  logic            sh_out_tvalid;
  logic            sh_out_tready;
  logic            sh_out_tlast = 1'b0;
  logic [DW-1:0]   sh_out_tdata = '0;
  logic [CW-1:0]   inflight;
  logic            err_orphan;

  logic            inject = 1'b0;
  logic            mdl_valid = 1'b0;

  always #5 clk = ~clk;

  assign sh_out_tvalid = inject | mdl_valid;

  piradip_shift_arbiter #(
    .NUM_REQ      (N),
    .DATA_WIDTH   (DW),
    .SHIFT_WIDTH  (SW),
    .MAX_INFLIGHT (MI)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_tvalid    (req_tvalid),
    .req_tready    (req_tready),
    .req_tdata     (req_tdata),
    .req_tlast     (req_tlast),
    .rsp_tvalid    (rsp_tvalid),
    .rsp_tready    (rsp_tready),
    .rsp_tdata     (rsp_tdata),
    .rsp_tlast     (rsp_tlast),
    .sh_in_tvalid  (sh_in_tvalid),
    .sh_in_tready  (sh_in_tready),
    .sh_in_tlast   (sh_in_tlast),
    .sh_in_tdata   (sh_in_tdata),
    .sh_out_tvalid (sh_out_tvalid),
    .sh_out_tready (sh_out_tready),
    .sh_out_tlast  (sh_out_tlast),
    .sh_out_tdata  (sh_out_tdata),
    .inflight      (inflight),
    .err_orphan    (err_orphan)
  );

  typedef struct {
    logic [W-1:0]  tdata;
    logic          last;
    logic [DW-1:0] exp;
  } beat_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            t;
  } pipe_t;

  beat_t         lane_q [N][$];
  logic [DW:0]   exp_q  [N][$];
  pipe_t         pipe_q [$];
  int            log_lane [$];
  int            log_cyc  [$];
  int            rsp_cyc  [$];
  int            rsp_cnt = 0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  beat_t         drv_b;
  pipe_t         drv_p;
  logic [DW:0]   mon_e;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(logic [SW-1:0] s, logic [DW-1:0] d);
    return {s, d};
  endfunction

  task automatic add(int ln, logic [SW-1:0] s, logic [DW-1:0] d,
                     logic l, logic [DW-1:0] e);
    beat_t b;
    b.tdata = mk(s, d);
    b.last  = l;
    b.exp   = e;
    lane_q[ln].push_back(b);
  endtask

  // Requester drivers and shifter model outputs change on the falling edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (lane_q[i].size() > 0) begin
        req_tvalid[i]        = 1'b1;
        req_tdata[i*W +: W]  = lane_q[i][0].tdata;
        req_tlast[i]         = lane_q[i][0].last;
      end else begin
        req_tvalid[i]        = 1'b0;
        req_tdata[i*W +: W]  = '0;
        req_tlast[i]         = 1'b0;
      end
    end
    if (pipe_q.size() > 0 && pipe_q[0].t <= cyc) begin
      mdl_valid    = 1'b1;
      sh_out_tdata = pipe_q[0].d;
      sh_out_tlast = pipe_q[0].l;
    end else begin
      mdl_valid    = 1'b0;
      sh_out_tdata = '0;
      sh_out_tlast = 1'b0;
    end
  end

  // Stimulus side: accepted beats queue their expected result.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        lane_q[i].delete();
        exp_q[i].delete();
      end
      pipe_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_tvalid[i] && req_tready[i]) begin
          drv_b = lane_q[i].pop_front();
          check("sh_in_tdata", 64'(sh_in_tdata), 64'(drv_b.tdata));
          check("sh_in_tlast", 64'(sh_in_tlast), 64'(drv_b.last));
          exp_q[i].push_back({drv_b.last, drv_b.exp});
          log_lane.push_back(i);
          log_cyc.push_back(cyc);
        end
      end
      if (sh_in_tvalid && sh_in_tready) begin
        drv_p.d = sh_in_tdata[DW-1:0] << sh_in_tdata[W-1:DW];
        drv_p.l = sh_in_tlast;
        drv_p.t = cyc + LAT;
        pipe_q.push_back(drv_p);
      end
      if (sh_out_tvalid && sh_out_tready && !inject && pipe_q.size() > 0)
        void'(pipe_q.pop_front());
    end
  end

  // Monitor: pops the scoreboard whenever a result is delivered.
  always @(posedge clk) begin
    if (!reset) begin
      if (inflight == CW'(MI))
        check("full_blocks_push", 64'(sh_in_tvalid), 64'(0));
      for (int i = 0; i < N; i++) begin
        if (rsp_tvalid[i] && rsp_tready[i]) begin
          check("rsp_expected", 64'(exp_q[i].size() > 0), 64'(1));
          if (exp_q[i].size() > 0) begin
            mon_e = exp_q[i].pop_front();
            check("rsp_tdata", 64'(rsp_tdata), 64'(mon_e[DW-1:0]));
            check("rsp_tlast", 64'(rsp_tlast), 64'(mon_e[DW]));
          end
          rsp_cnt++;
          rsp_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    log_lane.delete();
    log_cyc.delete();
  endtask

  task automatic wait_rsp(int n, int budget);
    int k;
    k = 0;
    while (rsp_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("rsp_timeout", 64'(rsp_cnt >= n), 64'(1));
  endtask

  task automatic wait_log(int n, int budget);
    int k;
    k = 0;
    while (log_lane.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("grant_timeout", 64'(log_lane.size() >= n), 64'(1));
  endtask

  int base;
  int rbase;
  int rr_exp [8] = '{0, 0, 1, 1, 3, 3, 0, 0};

  initial begin
    do_reset();
    #1;
    check("rst_inflight", 64'(inflight), 64'(0));
    check("rst_err", 64'(err_orphan), 64'(0));
    check("rst_req_tready", 64'(req_tready), 64'(0));
    check("rst_sh_in_tvalid", 64'(sh_in_tvalid), 64'(0));
    check("rst_rsp_tvalid", 64'(rsp_tvalid), 64'(0));
    check("rst_sh_out_tready", 64'(sh_out_tready), 64'(0));

    // Single beat
    base = rsp_cnt;
    add(0, 6'd4, 32'h1, 1'b1, 32'h10);
    wait_rsp(base + 1, 50);
    wait_log(1, 5);
    check("single_lane", 64'(log_lane[0]), 64'(0));
    @(negedge clk);
    check("single_inflight", 64'(inflight), 64'(0));

    // Round robin over lanes 0,1,3
    do_reset();
    base = rsp_cnt;
    add(0, 6'd1,  32'h3,    1'b0, 32'h6);
    add(0, 6'd2,  32'h3,    1'b1, 32'hC);
    add(0, 6'd0,  32'hAA,   1'b0, 32'hAA);
    add(0, 6'd4,  32'hF,    1'b1, 32'hF0);
    add(1, 6'd3,  32'h1,    1'b0, 32'h8);
    add(1, 6'd8,  32'hFF,   1'b1, 32'hFF00);
    add(3, 6'd16, 32'h1234, 1'b0, 32'h12340000);
    add(3, 6'd31, 32'h1,    1'b1, 32'h80000000);
    wait_rsp(base + 8, 200);
    wait_log(8, 5);
    for (int k = 0; k < 8; k++) begin
      if (k < log_lane.size())
        check("rr_lane", 64'(log_lane[k]), 64'(rr_exp[k]));
    end
    for (int k = 1; k < 8; k++) begin
      if (k < log_cyc.size())
        check("rr_gap", 64'(log_cyc[k] - log_cyc[k-1]),
              64'(((k % 2) == 1) ? 1 : 2));
    end

    // Backpressure and full boundary on lane 1
    do_reset();
    base = rsp_cnt;
    rsp_tready[1] = 1'b0;
    for (int k = 0; k < 10; k++)
      add(1, 6'd1, 32'(k + 1), 1'b0 | (k == 9), 32'((k + 1) * 2));
    repeat (20) @(negedge clk);
    check("bp_inflight", 64'(inflight), 64'(MI));
    check("bp_req_tready", 64'(req_tready), 64'(0));
    check("bp_accepted", 64'(log_lane.size()), 64'(MI));
    rbase = rsp_cyc.size();
    rsp_tready[1] = 1'b1;
    wait_rsp(base + 10, 200);
    wait_log(10, 5);
    if (log_cyc.size() > 8 && rsp_cyc.size() > rbase)
      check("full_push_next", 64'(log_cyc[8] - rsp_cyc[rbase]), 64'(1));
    @(negedge clk);
    check("bp_drained", 64'(inflight), 64'(0));

    // Orphan result
    do_reset();
    inject = 1'b1;
    #1;
    check("orph_sh_out_tready", 64'(sh_out_tready), 64'(0));
    check("orph_rsp_tvalid", 64'(rsp_tvalid), 64'(0));
    @(negedge clk);
    check("orph_set", 64'(err_orphan), 64'(1));
    inject = 1'b0;
    repeat (3) @(negedge clk);
    check("orph_sticky", 64'(err_orphan), 64'(1));
    do_reset();
    #1;
    check("orph_cleared", 64'(err_orphan), 64'(0));

    // Reset in the middle of a lane 2 packet
    base = rsp_cnt;
    add(1, 6'd2, 32'h5, 1'b1, 32'h14);
    wait_rsp(base + 1, 50);
    log_lane.delete();
    log_cyc.delete();
    for (int k = 0; k < 4; k++)
      add(2, 6'd1, 32'(k + 1), 1'b0 | (k == 3), 32'((k + 1) * 2));
    wait_log(1, 20);
    reset = 1'b1;
    #1;
    check("mid_req_tready", 64'(req_tready), 64'(0));
    check("mid_sh_in_tvalid", 64'(sh_in_tvalid), 64'(0));
    @(negedge clk);
    check("mid_inflight", 64'(inflight), 64'(0));
    check("mid_rsp_tvalid", 64'(rsp_tvalid), 64'(0));
    reset = 1'b0;
    log_lane.delete();
    log_cyc.delete();
    base = rsp_cnt;
    add(3, 6'd4, 32'h1,  1'b1, 32'h10);
    add(0, 6'd0, 32'h77, 1'b1, 32'h77);
    wait_rsp(base + 2, 100);
    wait_log(2, 5);
    if (log_lane.size() > 1) begin
      check("mid_first_grant", 64'(log_lane[0]), 64'(0));
      check("mid_second_grant", 64'(log_lane[1]), 64'(3));
    end

    repeat (5) @(negedge clk);
    for (int i = 0; i < N; i++)
      check("sb_empty", 64'(exp_q[i].size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
